// File: rtl/lfsr_dec_pkg.sv
// Shared types and constants for the LFSR stream-decrypt sequencer.
package lfsr_dec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRE,
    MSG,
    DONE,
    ERR
  } state_e;

  localparam logic [7:0] PRE_CHAR_DEFAULT = 8'h5F;

endpackage

// File: rtl/lfsr_dec_cnt.sv
// Per-phase word counter with clear, enable and a terminal-count flag
// raised when the count reaches the selected length minus one.
module lfsr_dec_cnt #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [AW-1:0] len,
  output logic [AW-1:0] cnt,
  output logic          last
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] cnt_q;

  // Clear wins over enable so a phase change always restarts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == (len - ONE));

endmodule

// File: rtl/lfsr_dec_seq.sv
// Sequencer for the LFSR stream-decrypt datapath: seed load, checked
// preamble, then a back-pressured message phase toward the sink.
module lfsr_dec_seq
  import lfsr_dec_pkg::*;
#(
  parameter int unsigned    DW        = 8,
  parameter int unsigned    AW        = 8,
  parameter logic [DW-1:0]  PRE_CHAR  = PRE_CHAR_DEFAULT,
  parameter bit             CHECK_PRE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] pre_len,
  input  logic [AW-1:0] msg_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dec_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          load_lfsr,
  output logic          lfsr_en,
  output logic [AW-1:0] word_cnt,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_e        state_q, state_d;
  logic [AW-1:0] preLen_q, msgLen_q;
  logic [AW-1:0] cmpLen;
  logic          latchLen, cntClr, cntEn, cntLast, xferIn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      preLen_q <= '0;
      msgLen_q <= '0;
    end else begin
      state_q <= state_d;
      if (latchLen) begin
        preLen_q <= pre_len;
        msgLen_q <= msg_len;
      end
    end
  end

  assign cmpLen = (state_q == MSG) ? msgLen_q : preLen_q;

  lfsr_dec_cnt #(.AW(AW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cntClr),
    .en   (cntEn),
    .len  (cmpLen),
    .cnt  (word_cnt),
    .last (cntLast)
  );

  // Abort is applied last so it overrides every transition and strobe.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_lfsr = 1'b0;
    lfsr_en   = 1'b0;
    cntClr    = 1'b0;
    cntEn     = 1'b0;
    latchLen  = 1'b0;
    xferIn    = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          latchLen = 1'b1;
          cntClr   = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        in_ready  = 1'b1;
        load_lfsr = in_valid;
        xferIn    = in_valid;
        if (xferIn) begin
          cntClr = 1'b1;
          if (preLen_q != '0)      state_d = PRE;
          else if (msgLen_q != '0) state_d = MSG;
          else                     state_d = DONE;
        end
      end
      PRE: begin
        in_ready = 1'b1;
        xferIn   = in_valid;
        lfsr_en  = xferIn;
        if (xferIn) begin
          if (CHECK_PRE && (dec_data != PRE_CHAR)) begin
            state_d = ERR;
          end else if (cntLast) begin
            cntClr  = 1'b1;
            state_d = (msgLen_q != '0) ? MSG : DONE;
          end else begin
            cntEn = 1'b1;
          end
        end
      end
      MSG: begin
        out_valid = in_valid;
        in_ready  = out_ready;
        xferIn    = in_valid & out_ready;
        lfsr_en   = xferIn;
        if (xferIn) begin
          if (cntLast) state_d = DONE;
          else         cntEn   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load_lfsr = 1'b0;
      lfsr_en   = 1'b0;
      cntClr    = 1'b1;
      cntEn     = 1'b0;
      latchLen  = 1'b0;
    end
  end

  assign busy = (state_q == LOAD) || (state_q == PRE) || (state_q == MSG);
  assign done = (state_q == DONE);
  assign err  = (state_q == ERR);

endmodule

// File: tb/tb_lfsr_dec_seq.sv
// Scoreboarded bench for lfsr_dec_seq; a second instance with the
// preamble check disabled shares the same stimulus.
module tb_lfsr_dec_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] preLen;
  logic [7:0] msgLen;
  logic       inValid;
  logic [7:0] decData;
  logic       outReady;

  logic       inReady, outValid, loadLfsr, lfsrEn, busy, done, err;
  logic [7:0] wordCnt;
  logic       inReadyB, outValidB, loadLfsrB, lfsrEnB, busyB, doneB, errB;
  logic [7:0] wordCntB;

  int vectorsApplied = 0;
  int miscompares    = 0;
  int loadCount      = 0;
  int lfsrCount      = 0;
  int xferCount      = 0;
  int ovCount        = 0;
  logic [7:0] expQ[$];

  lfsr_dec_seq #(.DW(8), .AW(8), .PRE_CHAR(8'h5F), .CHECK_PRE(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pre_len(preLen), .msg_len(msgLen),
    .in_valid(inValid), .in_ready(inReady), .dec_data(decData),
    .out_valid(outValid), .out_ready(outReady),
    .load_lfsr(loadLfsr), .lfsr_en(lfsrEn), .word_cnt(wordCnt),
    .busy(busy), .done(done), .err(err)
  );

  lfsr_dec_seq #(.DW(8), .AW(8), .PRE_CHAR(8'h5F), .CHECK_PRE(1'b0)) dutNoChk (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pre_len(preLen), .msg_len(msgLen),
    .in_valid(inValid), .in_ready(inReadyB), .dec_data(decData),
    .out_valid(outValidB), .out_ready(outReady),
    .load_lfsr(loadLfsrB), .lfsr_en(lfsrEnB), .word_cnt(wordCntB),
    .busy(busyB), .done(doneB), .err(errB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops the expected word count at every sink transfer.
  always @(negedge clk) begin
    if (loadLfsr) loadCount++;
    if (lfsrEn)   lfsrCount++;
    if (outValid) ovCount++;
    if (outValid && outReady) begin
      xferCount++;
      checkOutput("sb entry available", 32'(expQ.size() > 0), 1);
      if (expQ.size() > 0) checkOutput("msg word_cnt", 32'(wordCnt), 32'(expQ.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic vld,
                               input logic [7:0] data, input logic ordy);
    start    = st;
    abort    = ab;
    inValid  = vld;
    decData  = data;
    outReady = ordy;
    #1;
  endtask

  task automatic startRun(input logic [7:0] p, input logic [7:0] m);
    preLen = p;
    msgLen = m;
    applyStimulus(1, 0, 0, 8'h00, 1);
    tick();
    applyStimulus(0, 0, 0, 8'h00, 1);
  endtask

  task automatic preWord(input logic [7:0] data);
    applyStimulus(0, 0, 1, data, 1);
    tick();
  endtask

  task automatic msgWord(input logic [7:0] data, input logic [7:0] cnt);
    applyStimulus(0, 0, 1, data, 1);
    expQ.push_back(cnt);
    tick();
  endtask

  int baseLoad, baseLfsr, baseXfer, baseOv, k;
  logic [3:0] ordyPat;

  initial begin
    rst = 1'b1;
    preLen = 8'd0;
    msgLen = 8'd0;
    applyStimulus(0, 0, 0, 8'h00, 1);
    tick();
    tick();
    checkOutput("reset outputs", {busy, done, err, inReady, outValid, loadLfsr, lfsrEn, wordCnt}, 0);
    rst = 1'b0;
    tick();
    checkOutput("post-reset outputs", {busy, done, err, inReady, outValid, loadLfsr, lfsrEn, wordCnt}, 0);

    // 1: nominal run
    $display("[TB] nominal run");
    baseLoad = loadCount; baseLfsr = lfsrCount; baseXfer = xferCount; baseOv = ovCount;
    startRun(8'd3, 8'd4);
    checkOutput("busy in LOAD", busy, 1);
    applyStimulus(0, 0, 1, 8'hA5, 1);
    checkOutput("load_lfsr on seed", loadLfsr, 1);
    checkOutput("lfsr_en on seed", lfsrEn, 0);
    tick();
    preWord(8'h5F);
    checkOutput("pre word_cnt", wordCnt, 1);
    preWord(8'h5F);
    preWord(8'h5F);
    checkOutput("MSG word_cnt start", wordCnt, 0);
    for (int i = 0; i < 4; i++) msgWord(8'h10 + 8'(i), 8'(i));
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkOutput("done after msg", {busy, done, err}, 3'b010);
    checkOutput("load pulses", loadCount - baseLoad, 1);
    checkOutput("lfsr_en pulses", lfsrCount - baseLfsr, 7);
    checkOutput("out_valid cycles", ovCount - baseOv, 4);
    checkOutput("msg transfers", xferCount - baseXfer, 4);

    // 2: back-pressure, restarted straight from DONE
    $display("[TB] back-pressure");
    baseLfsr = lfsrCount; baseXfer = xferCount;
    startRun(8'd3, 8'd4);
    applyStimulus(0, 0, 1, 8'hA5, 1);
    tick();
    for (int i = 0; i < 3; i++) preWord(8'h5F);
    ordyPat = 4'b1001;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      logic r;
      r = (i < 4) ? ordyPat[3-i] : 1'b1;
      applyStimulus(0, 0, 1, 8'h20 + 8'(i), r);
      checkOutput("in_ready follows out_ready", inReady, r);
      if (r) begin
        expQ.push_back(8'(k));
        k++;
      end else begin
        checkOutput("stall lfsr_en", lfsrEn, 0);
        checkOutput("stall word_cnt", wordCnt, k);
      end
      tick();
    end
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkOutput("bp done", done, 1);
    checkOutput("bp transfers", xferCount - baseXfer, 4);
    checkOutput("bp lfsr_en pulses", lfsrCount - baseLfsr, 7);

    // 3: preamble mismatch, with and without the check
    $display("[TB] preamble mismatch");
    startRun(8'd3, 8'd4);
    applyStimulus(0, 0, 1, 8'hA5, 1);
    tick();
    preWord(8'h5F);
    preWord(8'h41);
    checkOutput("err after mismatch", {busy, done, err}, 3'b001);
    checkOutput("no-check instance busy", busyB, 1);
    applyStimulus(0, 0, 1, 8'h5F, 1);
    checkOutput("in_ready in ERR", inReady, 0);
    tick();
    for (int i = 0; i < 4; i++) preWord(8'h30 + 8'(i));
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkOutput("no-check instance done", doneB, 1);
    checkOutput("err held", err, 1);

    // 4: zero-length phases
    $display("[TB] zero lengths");
    startRun(8'd0, 8'd2);
    applyStimulus(0, 0, 1, 8'hA5, 1);
    tick();
    applyStimulus(0, 0, 1, 8'h40, 1);
    checkOutput("LOAD->MSG out_valid", outValid, 1);
    expQ.push_back(8'd0);
    tick();
    msgWord(8'h41, 8'd1);
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkOutput("pre0 done", done, 1);
    baseOv = ovCount;
    startRun(8'd0, 8'd0);
    applyStimulus(0, 0, 1, 8'hA5, 1);
    tick();
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkOutput("empty run done", {busy, done, err}, 3'b010);
    checkOutput("empty run out_valid", ovCount - baseOv, 0);

    // 5: abort together with start mid-MSG, then restart from DONE
    $display("[TB] abort and restart");
    startRun(8'd2, 8'd4);
    applyStimulus(0, 0, 1, 8'hA5, 1);
    tick();
    preWord(8'h5F);
    preWord(8'h5F);
    msgWord(8'h50, 8'd0);
    msgWord(8'h51, 8'd1);
    applyStimulus(1, 1, 1, 8'h52, 1);
    checkOutput("abort lfsr_en", lfsrEn, 0);
    checkOutput("abort in_ready", inReady, 0);
    tick();
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkOutput("idle after abort", {busy, done, err, wordCnt}, 0);
    startRun(8'd0, 8'd0);
    applyStimulus(0, 0, 1, 8'hA5, 1);
    tick();
    startRun(8'd1, 8'd1);
    preLen = 8'd0;
    msgLen = 8'd0;
    applyStimulus(0, 0, 1, 8'hA6, 1);
    tick();
    applyStimulus(0, 0, 1, 8'h5F, 1);
    checkOutput("restart in PRE out_valid", outValid, 0);
    checkOutput("restart in PRE lfsr_en", lfsrEn, 1);
    tick();
    msgWord(8'h77, 8'd0);
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkOutput("restart done", done, 1);

    // 6: asynchronous reset in the middle of PRE
    $display("[TB] async reset");
    startRun(8'd3, 8'd1);
    applyStimulus(0, 0, 1, 8'hA5, 1);
    tick();
    preWord(8'h5F);
    applyStimulus(0, 0, 1, 8'h5F, 1);
    rst = 1'b1;
    #1;
    checkOutput("async reset outputs", {busy, done, err, inReady, outValid, loadLfsr, lfsrEn, wordCnt}, 0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 8'h00, 1);
    tick();
    startRun(8'd1, 8'd1);
    applyStimulus(0, 0, 1, 8'hA5, 1);
    tick();
    preWord(8'h5F);
    msgWord(8'h66, 8'd0);
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkOutput("run after reset done", done, 1);

    tick();
    checkOutput("sb queue drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/lfsr_dec_seq.md
Name: lfsr_dec_seq

Overview:
Parametrised sequencing controller for the LFSR stream-decrypt datapath. It loads the LFSR seed from the first input word and consumes a runtime-programmable preamble. It checks each decrypted preamble word against an expected character, then passes a runtime-programmable number of message words to a downstream consumer. Valid/ready is used on both sides, so the block supports back-pressure. It sits between the encrypted-word source and the LFSR/XOR datapath plus output sink, replacing the fixed-flag sequencer.

Parameters:
DW, 8, data word width (seed and decrypted word)
AW, 8, width of pre_len, msg_len and the per-phase word counter
PRE_CHAR, 8'h5F, expected decrypted preamble word (DW bits)
CHECK_PRE, 1, 1 = preamble mismatch aborts to ERR; 0 = no check

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin a run; sampled in IDLE, DONE, ERR
abort  in  1  synchronous abort to IDLE, any state
pre_len  in  AW  preamble word count, latched on accepted start
msg_len  in  AW  message word count, latched on accepted start
in_valid  in  1  source word available
in_ready  out  1  source word consumed this cycle
dec_data  in  DW  decrypted word from datapath (current LFSR XOR input)
out_valid  out  1  decrypted message word valid to sink
out_ready  in  1  sink accepts word
load_lfsr  out  1  load LFSR seed from current input word
lfsr_en  out  1  advance LFSR one step
word_cnt  out  AW  words consumed in current phase
busy  out  1  state is LOAD, PRE or MSG
done  out  1  state is DONE
err  out  1  state is ERR

Behaviour:
- Reset (async, rst=1): state IDLE, word_cnt=0, latched lengths=0. All outputs 0 while reset is asserted and immediately after.
- States: IDLE, LOAD, PRE, MSG, DONE, ERR. busy/done/err decode directly from the state register.
- in_ready, out_valid, load_lfsr and lfsr_en are combinational from state and handshake inputs. There is zero added latency.
- xfer_in = in_valid & in_ready.
- IDLE: in_ready=0. start=1 latches pre_len/msg_len, clears word_cnt, goes to LOAD.
- LOAD: in_ready=1; load_lfsr=in_valid. On xfer_in: go to PRE if pre_len_q!=0, else MSG if msg_len_q!=0, else DONE. word_cnt clears.
- PRE: in_ready=1; lfsr_en=xfer_in; out_valid=0 (preamble is never forwarded).
  - On xfer_in, if CHECK_PRE=1 and dec_data!=PRE_CHAR: go to ERR.
  - Else, if word_cnt==pre_len_q-1: go to MSG (or DONE if msg_len_q==0) and clear word_cnt.
  - Otherwise word_cnt+1.
- MSG: out_valid=in_valid; in_ready=out_ready; lfsr_en=xfer_in.
  - On xfer_in with word_cnt==msg_len_q-1: go to DONE.
  - Otherwise word_cnt+1 on xfer_in.
  - Stalls (in_valid=0 or out_ready=0) hold all state and do not step the LFSR.
- DONE / ERR: in_ready=0, out_valid=0. The state and its flag are held.
  - start=1 goes to LOAD with new lengths latched (restart without passing through IDLE).
- abort=1 has priority over every transition, including start in the same cycle. Next state is IDLE with word_cnt=0.
  - No output strobe fires in the abort cycle: in_ready, load_lfsr and lfsr_en are forced to 0.
- A start asserted in LOAD, PRE or MSG is ignored.
- Length changes on pre_len/msg_len mid-run are ignored; only the latched copies are used.
- word_cnt never wraps within a phase. The maximum phase length is 2^AW-1 words.
- rst asserted mid-run immediately forces IDLE and clears all outputs, with no dependence on the clock.
- All next-state and output logic is fully assigned with defaults in every branch. No latches.

Decomposition:
- Package lfsr_dec_pkg:
  - state enum (IDLE, LOAD, PRE, MSG, DONE, ERR)
  - default PRE_CHAR constant
- Sub-module lfsr_dec_cnt: AW-bit counter with clear, enable and terminal-count compare against a latched length. The top instantiates one and selects the compare length by phase.

Test Plan:
1. Nominal run, pre_len=3, msg_len=4, CHECK_PRE=1; seed word then dec_data=8'h5F for 3 words, then 4 message words; out_ready=1 always.
   -> load_lfsr=1 for exactly one cycle; lfsr_en pulses 7 times; out_valid high for 4 cycles; done=1 on the cycle after the 4th transfer.
2. Back-pressure: same run with out_ready toggling 1,0,0,1 during MSG.
   -> in_ready follows out_ready; lfsr_en and word_cnt frozen on stall cycles; still exactly 4 message transfers before done.
3. Preamble mismatch: dec_data=8'h41 on the 2nd preamble word.
   -> err=1 the next cycle; in_ready=0 thereafter.
   -> Repeat with CHECK_PRE=0: run completes with done=1.
4. Zero lengths:
   -> pre_len=0, msg_len=2: LOAD goes straight to MSG.
   -> pre_len=0, msg_len=0: DONE one cycle after the seed transfer; out_valid never asserts.
5. Abort and restart: abort=1 and start=1 together mid-MSG.
   -> IDLE next cycle, no lfsr_en in that cycle.
   -> A later start from DONE re-enters LOAD with the newly latched lengths.
6. Async reset: assert rst between clock edges during PRE.
   -> state IDLE and all outputs 0 before the next rising edge; a normal run succeeds after release.
